// File: rtl/dc_ctrl_pkg.sv
// Shared types and helpers for the data-cache miss sequencer.
package dc_ctrl_pkg;

  localparam int unsigned LINE_BITS = 128;
  localparam int unsigned OFS_BITS  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdVict,
    StWbCap,
    StWbReq,
    StFillReq,
    StFillWr,
    StFin,
    StFin2
  } dc_state_e;

  typedef enum logic {
    BufSrcRam,
    BufSrcMem
  } buf_src_e;

  // Line index of a byte address for a data RAM with dwidth word-address bits.
  function automatic logic [31:0] dc_line_idx(input logic [31:0] adr, input int unsigned dwidth);
    logic [31:0] mask;
    mask = (32'd1 << (dwidth - 2)) - 32'd1;
    return (adr >> OFS_BITS) & mask;
  endfunction

endpackage

// File: rtl/dc_line_buf.sv
// Single 128-bit line buffer shared by the victim write-back and the fill.
module dc_line_buf
  import dc_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  buf_src_e             sel_i,
  input  logic [LINE_BITS-1:0] ram_data_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic [LINE_BITS-1:0] line_o
);

  logic [LINE_BITS-1:0] line_q, line_d;

  // Select the load source; hold otherwise.
  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = (sel_i == BufSrcMem) ? mem_data_i : ram_data_i;
    end
  end

  // Line storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/dc_miss_ctrl.sv
// Data-cache miss sequencer: stall, optional dirty-victim write-back, line fill,
// then the two-pulse completion handshake.
// Write-back support is built only when DC_WRITEBACK_EN is defined; otherwise
// the cache is write-through and every miss goes straight to the fill.
module dc_miss_ctrl
  import dc_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dc_miss_req,
  input  logic [31:0]              dc_miss_adr,
  input  logic                     dc_victim_dirty,
  input  logic [32-(DWIDTH+2)-1:0] dc_victim_tag,
  output logic                     dc_stall,
  output logic                     dc_stall_fin,
  output logic                     dc_stall_fin2,
  output logic                     dc_tag_wen,
  output logic [DWIDTH-3:0]        ram_radr_all,
  output logic                     ram_ren_all,
  input  logic [LINE_BITS-1:0]     ram_rdata_all,
  output logic [DWIDTH-3:0]        ram_wadr_all,
  output logic [LINE_BITS-1:0]     ram_wdata_all,
  output logic                     ram_wen_all,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [27:0]              mem_adr,
  output logic [LINE_BITS-1:0]     mem_wdata,
  input  logic                     mem_ack,
  input  logic [LINE_BITS-1:0]     mem_rdata
);

  localparam int unsigned IdxW = DWIDTH - 2;

  dc_state_e            state_q, state_d;
  logic [31-OFS_BITS:0] line_adr_q, line_adr_d;
  logic                 stall_q, stall_d;
  logic [IdxW-1:0]      idx;
  logic                 buf_load;
  buf_src_e             buf_sel;
  logic [LINE_BITS-1:0] line_buf;
  logic                 unused_in;

`ifdef DC_WRITEBACK_EN
  localparam int unsigned TagW = 32 - (DWIDTH + 2);
  logic [TagW-1:0] vtag_q, vtag_d;
  assign unused_in = ^dc_miss_adr[OFS_BITS-1:0];
`else
  // Victim information is meaningless for a write-through cache.
  assign unused_in = ^{dc_miss_adr[OFS_BITS-1:0], dc_victim_dirty, dc_victim_tag};
`endif

  assign idx      = IdxW'(dc_line_idx({line_adr_q, {OFS_BITS{1'b0}}}, DWIDTH));
  assign dc_stall = stall_q;

  dc_line_buf u_line_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (buf_load),
    .sel_i      (buf_sel),
    .ram_data_i (ram_rdata_all),
    .mem_data_i (mem_rdata),
    .line_o     (line_buf)
  );

  // State, captured miss context and registered stall decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      line_adr_q <= '0;
      stall_q    <= 1'b0;
`ifdef DC_WRITEBACK_EN
      vtag_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      line_adr_q <= line_adr_d;
      stall_q    <= stall_d;
`ifdef DC_WRITEBACK_EN
      vtag_q     <= vtag_d;
`endif
    end
  end

  // Next-state logic; a miss is only captured in StIdle.
  always_comb begin
    state_d    = state_q;
    line_adr_d = line_adr_q;
`ifdef DC_WRITEBACK_EN
    vtag_d     = vtag_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (dc_miss_req) begin
          line_adr_d = dc_miss_adr[31:OFS_BITS];
`ifdef DC_WRITEBACK_EN
          vtag_d     = dc_victim_tag;
          state_d    = dc_victim_dirty ? StRdVict : StFillReq;
`else
          state_d    = StFillReq;
`endif
        end
      end
`ifdef DC_WRITEBACK_EN
      StRdVict: state_d = StWbCap;
      StWbCap:  state_d = StWbReq;
      StWbReq:  if (mem_ack) state_d = StFillReq;
`endif
      StFillReq: if (mem_ack) state_d = StFillWr;
      StFillWr:  state_d = StFin;
      StFin:     state_d = StFin2;
      StFin2:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    stall_d = (state_d != StIdle);
  end

  // Moore outputs; every bus is zero outside the state that drives it, so
  // reset clears them immediately.
  always_comb begin
    dc_stall_fin  = 1'b0;
    dc_stall_fin2 = 1'b0;
    dc_tag_wen    = 1'b0;
    ram_radr_all  = '0;
    ram_ren_all   = 1'b0;
    ram_wadr_all  = '0;
    ram_wdata_all = '0;
    ram_wen_all   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_adr       = '0;
    mem_wdata     = '0;
    buf_load      = 1'b0;
    buf_sel       = BufSrcMem;
    unique case (state_q)
`ifdef DC_WRITEBACK_EN
      StRdVict: begin
        ram_ren_all  = 1'b1;
        ram_radr_all = idx;
      end
      StWbCap: begin
        buf_load = 1'b1;
        buf_sel  = BufSrcRam;
      end
      StWbReq: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = {vtag_q, idx};
        mem_wdata = line_buf;
      end
`endif
      StFillReq: begin
        mem_req  = 1'b1;
        mem_adr  = line_adr_q;
        buf_load = mem_ack;
        buf_sel  = BufSrcMem;
      end
      StFillWr: begin
        ram_wen_all   = 1'b1;
        ram_wadr_all  = idx;
        ram_wdata_all = line_buf;
        dc_tag_wen    = 1'b1;
      end
      StFin:   dc_stall_fin  = 1'b1;
      StFin2:  dc_stall_fin2 = 1'b1;
      default: ;
    endcase
  end

endmodule
